// File: rtl/iw_trace_pkg.sv
// rtl/iw_trace_pkg.sv - opcodes, ASCII constants and FSM states for the IW trace
package iw_trace_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_INC  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_CPY  = 4'h7;
  localparam logic [3:0] OP_SHRA = 4'h8;
  localparam logic [3:0] OP_SHXL = 4'h9;
  localparam logic [3:0] OP_RXC  = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hC;
  localparam logic [3:0] OP_JUMP = 4'hD;
  localparam logic [3:0] OP_IN   = 4'hE;
  localparam logic [3:0] OP_OUT  = 4'hF;

  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_T    = 8'h54;
  localparam logic [7:0] CH_HASH = 8'h23;

  // every decoded instruction text is exactly this many characters before padding
  localparam int BASE_LEN = 12;

  typedef enum logic [2:0] {
    ST_BANNER,
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_CR,
    ST_LF
  } state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? CH_0 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/iw_ascii_decode.sv
// rtl/iw_ascii_decode.sv - combinational IW to ASCII line decoder (char 0 in the low byte)
module iw_ascii_decode
  import iw_trace_pkg::*;
#(
  parameter int LINE_LEN = 12
) (
  input  logic [7:0]            iw,
  output logic [LINE_LEN*8-1:0] line
);

  logic [BASE_LEN*8-1:0] base;
  logic [39:0]           mnem;
  logic                  imm;
  logic [7:0]            rx;
  logic [7:0]            ry;
  logic [7:0]            cond;

  always_comb begin
    mnem = "     ";
    imm  = 1'b0;
    rx   = CH_0 + {6'b0, iw[3:2]};
    ry   = CH_0 + {6'b0, iw[1:0]};
    case (iw[7:4])
      OP_ADD:  mnem = "ADD  ";
      OP_SUB:  mnem = "SUB  ";
      OP_INC:  begin mnem = "INC  "; imm = 1'b1; end
      OP_DEC:  begin mnem = "DEC  "; imm = 1'b1; end
      OP_XOR:  mnem = "XOR  ";
      OP_AND:  mnem = "AND  ";
      OP_OR:   mnem = "OR   ";
      OP_CPY:  mnem = "CPY  ";
      OP_SHRA: begin mnem = "SHRA "; imm = 1'b1; end
      OP_SHXL: begin mnem = "SHxL "; imm = 1'b1; end
      OP_RXC:  begin mnem = "RxC  "; imm = 1'b1; end
      OP_LD:   mnem = "LD   ";
      OP_ST:   mnem = "ST   ";
      OP_JUMP: mnem = "JUMP ";
      OP_IN:   mnem = "IN   ";
      OP_OUT:  mnem = "OUT  ";
      default: mnem = "     ";
    endcase
    case (iw[3:0])
      4'b0000: cond = "U";
      4'b1000: cond = "C";
      4'b0100: cond = "N";
      4'b0010: cond = "V";
      4'b0001: cond = "Z";
      default: cond = "?";
    endcase
    // base holds the text in reading order, first character in the top byte
    case (iw[7:4])
      OP_LD, OP_ST: base = {mnem, CH_R, rx, ", MA;"};
      OP_JUMP:      base = {"JUMP if ", cond, "=1;"};
      OP_IN:        base = {"IN R", rx, ", PBSW;"};
      OP_OUT:       base = {"OUT R", rx, ", LED;"};
      default:      base = {mnem, CH_R, rx, ", ", (imm ? CH_HASH : CH_R), ry, ";"};
    endcase
  end

  for (genvar i = 0; i < LINE_LEN; i++) begin : g_char
    if (i < BASE_LEN) begin : g_text
      assign line[i*8 +: 8] = base[(BASE_LEN-1-i)*8 +: 8];
    end else begin : g_pad
      assign line[i*8 +: 8] = CH_SP;
    end
  end

endmodule

// File: rtl/iw_trace_ascii.sv
// rtl/iw_trace_ascii.sv - IW trace FIFO and ASCII line streamer
// IW_TRACE_PC_EN adds a "hh: " PC prefix to every line.
module iw_trace_ascii
  import iw_trace_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int LINE_LEN = 12,
  parameter int CNT_W    = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iw_valid,
  input  logic [7:0]       iw,
  input  logic [7:0]       pc,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_char,
  output logic             full,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
`ifdef IW_TRACE_PC_EN
  localparam int EW  = 16;
  localparam int TOT = LINE_LEN + 4;
`else
  localparam int EW  = 8;
  localparam int TOT = LINE_LEN;
`endif
  localparam int IDX_W = $clog2(TOT);

  logic [EW-1:0]       mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                empty;
  logic                push;
  logic [EW-1:0]       head;
  logic [EW-1:0]       wr_data;
  logic [LINE_LEN*8-1:0] dec_line;
  logic [TOT*8-1:0]    load_line;
  logic [TOT*8-1:0]    line_reg;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  state_t              state;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = iw_valid && !full;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign idx_nxt = idx + 1'b1;

`ifdef IW_TRACE_PC_EN
  assign wr_data   = {pc, iw};
  assign load_line = {dec_line, CH_SP, 8'h3A, hex_char(head[11:8]), hex_char(head[15:12])};
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign wr_data   = iw;
  assign load_line = dec_line;
`endif

  iw_ascii_decode #(.LINE_LEN(LINE_LEN)) u_decode (
    .iw   (head[7:0]),
    .line (dec_line)
  );

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // full is judged before this edge's pop, so a push against a full FIFO is always lost
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (state == ST_LOAD) rd_ptr <= rd_ptr + 1'b1;
      if (iw_valid && full && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= ST_BANNER;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      idx       <= '0;
      line_reg  <= '0;
    end else begin
      case (state)
        ST_BANNER: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_char  <= CH_R;
            idx       <= '0;
          end else if (out_ready) begin
            if (idx == IDX_W'(2)) begin
              out_char <= CH_CR;
              state    <= ST_CR;
            end else begin
              idx      <= idx_nxt;
              out_char <= (idx_nxt == IDX_W'(1)) ? CH_S : CH_T;
            end
          end
        end
        ST_IDLE: begin
          out_valid <= 1'b0;
          if (!empty) state <= ST_LOAD;
        end
        // the first character is presented straight from the decoder
        ST_LOAD: begin
          line_reg  <= load_line;
          out_char  <= load_line[7:0];
          out_valid <= 1'b1;
          idx       <= '0;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            if (idx == IDX_W'(TOT-1)) begin
              out_char <= CH_CR;
              state    <= ST_CR;
            end else begin
              idx      <= idx_nxt;
              out_char <= line_reg[{idx_nxt, 3'b000} +: 8];
            end
          end
        end
        ST_CR: begin
          if (out_ready) begin
            out_char <= CH_LF;
            state    <= ST_LF;
          end
        end
        ST_LF: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= empty ? ST_IDLE : ST_LOAD;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iw_trace_ascii.sv
// tb/tb_iw_trace_ascii.sv - self-checking bench for iw_trace_ascii (scoreboard of expected characters)
module tb_iw_trace_ascii;

  localparam int DEPTH    = 16;
  localparam int LINE_LEN = 12;
  localparam int CNT_W    = 8;
  localparam int NVEC     = 21;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             iw_valid = 1'b0;
  logic [7:0]       iw = 8'h00;
  logic [7:0]       pc = 8'h00;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [7:0]       out_char;
  logic             full;
  logic [CNT_W-1:0] drop_cnt;

  always #5 Clock = ~Clock;

  iw_trace_ascii #(.DEPTH(DEPTH), .LINE_LEN(LINE_LEN), .CNT_W(CNT_W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iw_valid  (iw_valid),
    .iw        (iw),
    .pc        (pc),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_char  (out_char),
    .full      (full),
    .drop_cnt  (drop_cnt)
  );

  typedef struct packed {
    logic [7:0]  iw;
    logic [95:0] text;
  } vec_t;

  vec_t       vecs [NVEC];
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         failures = 0;
  logic       hold_pending = 1'b0;
  logic [7:0] held_char = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // beats are observed mid-cycle; one transfers at the next rising edge
  always @(negedge Clock) begin
    if (Reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_char", out_char, held_char);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_char, 32'hFFFF_FFFF);
        end else begin
          check("char", out_char, exp_q.pop_front());
        end
      end
      hold_pending = out_valid && !out_ready;
      held_char    = out_char;
    end
  end

  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic expect_line(input logic [95:0] text, input logic [7:0] p);
`ifdef IW_TRACE_PC_EN
    exp_q.push_back(hex_digit(p[7:4]));
    exp_q.push_back(hex_digit(p[3:0]));
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'h20);
`else
    if (p === 8'hxx) exp_q.push_back(8'hxx);
`endif
    for (int i = 0; i < 12; i++) exp_q.push_back(text[(11-i)*8 +: 8]);
    for (int i = 12; i < LINE_LEN; i++) exp_q.push_back(8'h20);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic expect_banner();
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h53);
    exp_q.push_back(8'h54);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_iw(input logic [7:0] w, input logic [7:0] p, input logic [95:0] text,
                         input bit expect_it);
    iw_valid = 1'b1;
    iw       = w;
    pc       = p;
    if (expect_it) expect_line(text, p);
    tick();
    iw_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_valid", out_valid, 0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", out_valid, 1);
  endtask

  initial begin
    logic seen;
    vecs[0]  = '{iw: 8'h06, text: "ADD  R1, R2;"};
    vecs[1]  = '{iw: 8'h1B, text: "SUB  R2, R3;"};
    vecs[2]  = '{iw: 8'h2D, text: "INC  R3, #1;"};
    vecs[3]  = '{iw: 8'h30, text: "DEC  R0, #0;"};
    vecs[4]  = '{iw: 8'h47, text: "XOR  R1, R3;"};
    vecs[5]  = '{iw: 8'h5E, text: "AND  R3, R2;"};
    vecs[6]  = '{iw: 8'h65, text: "OR   R1, R1;"};
    vecs[7]  = '{iw: 8'h7C, text: "CPY  R3, R0;"};
    vecs[8]  = '{iw: 8'h8A, text: "SHRA R2, #2;"};
    vecs[9]  = '{iw: 8'h93, text: "SHxL R0, #3;"};
    vecs[10] = '{iw: 8'hA5, text: "RxC  R1, #1;"};
    vecs[11] = '{iw: 8'hB4, text: "LD   R1, MA;"};
    vecs[12] = '{iw: 8'hC8, text: "ST   R2, MA;"};
    vecs[13] = '{iw: 8'hD8, text: "JUMP if C=1;"};
    vecs[14] = '{iw: 8'hD3, text: "JUMP if ?=1;"};
    vecs[15] = '{iw: 8'hD0, text: "JUMP if U=1;"};
    vecs[16] = '{iw: 8'hD4, text: "JUMP if N=1;"};
    vecs[17] = '{iw: 8'hD2, text: "JUMP if V=1;"};
    vecs[18] = '{iw: 8'hD1, text: "JUMP if Z=1;"};
    vecs[19] = '{iw: 8'hE6, text: "IN R1, PBSW;"};
    vecs[20] = '{iw: 8'hFB, text: "OUT R2, LED;"};

    // reset state and banner
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_char", out_char, 0);
    check("rst_full", full, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    expect_banner();
    Reset = 1'b0;
    wait_drain(40);
    repeat (3) tick();
    check("idle_after_banner", out_valid, 0);

    // first-character latency
    push_iw(vecs[0].iw, 8'h10, vecs[0].text, 1'b1);
    check("lat_e0", out_valid, 0);
    tick();
    check("lat_e1", out_valid, 0);
    tick();
    check("lat_e2", out_valid, 1);
    wait_drain(60);

    for (int i = 0; i < NVEC; i++) begin
      push_iw(vecs[i].iw, 8'h10 + 8'(i), vecs[i].text, 1'b1);
      wait_drain(60);
    end

`ifdef IW_TRACE_PC_EN
    push_iw(8'hB4, 8'h3A, "LD   R1, MA;", 1'b1);
    wait_drain(60);
`endif

    // back-pressure mid-line
    push_iw(8'h8A, 8'h20, "SHRA R2, #2;", 1'b1);
    wait_valid(10);
    repeat (3) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
`ifdef IW_TRACE_PC_EN
      check("stall_char", out_char, 8'h20);
`else
      check("stall_char", out_char, 8'h41);
`endif
      check("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    wait_drain(60);

    // overflow while the streamer is stalled
    out_ready = 1'b0;
    push_iw(8'h06, 8'h30, "ADD  R1, R2;", 1'b1);
    wait_valid(10);
    for (int k = 0; k < DEPTH + 3; k++) begin
      iw_valid = 1'b1;
      iw       = vecs[k].iw;
      pc       = 8'h40 + 8'(k);
      if (k < DEPTH) expect_line(vecs[k].text, 8'h40 + 8'(k));
      tick();
    end
    iw_valid = 1'b0;
    check("ovf_full", full, 1);
    check("ovf_drop_cnt", drop_cnt, 3);
    repeat (4) tick();
    check("ovf_full_held", full, 1);
    out_ready = 1'b1;
    wait_drain(DEPTH * 25 + 50);
    check("ovf_full_after", full, 0);
    check("ovf_drop_after", drop_cnt, 3);

    // reset in the middle of a line with more IWs queued
    out_ready = 1'b0;
    push_iw(8'hE6, 8'h55, "IN R1, PBSW;", 1'b1);
    wait_valid(10);
    push_iw(8'h06, 8'h56, "ADD  R1, R2;", 1'b0);
    push_iw(8'h1B, 8'h57, "SUB  R2, R3;", 1'b0);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
`ifdef IW_TRACE_PC_EN
    check("mid_idx4_char", out_char, 8'h49);
`else
    check("mid_idx4_char", out_char, 8'h31);
`endif
    Reset = 1'b1;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_char", out_char, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_drop", drop_cnt, 0);
    exp_q.delete();
    expect_banner();
    Reset = 1'b0;
    out_ready = 1'b1;
    wait_drain(40);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("fifo_flushed", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
